// File: rtl/fault_pkg.sv
// Shared definitions for the redundant fault-detection register bank:
// the FSM state encoding and a saturating increment.
package fault_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_MONITOR = 2'b01,
      ST_FAULT   = 2'b10
   } state_t;

   localparam int SAT_W = 64;

   // Callers zero-extend into SAT_W bits and truncate the result back.
   function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                                input logic [SAT_W-1:0] max_value);
      return (value >= max_value) ? value : value + 64'd1;
   endfunction

endpackage

// File: rtl/fault_reg_bank_if.sv
// Host-side bus of the fault register bank: arm/mode/pattern in,
// voted value and fault statistics out.
interface fault_reg_bank_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 5,
   parameter int CNT_W    = 16,
   parameter int TS_W     = 24
) ();
   logic                en;
   logic                mode;
   logic [WIDTH-1:0]    d;
   logic [WIDTH-1:0]    q;
   logic [CHANNELS-1:0] fault_mask;
   logic                fault_any;
   logic [CNT_W-1:0]    fault_count;
   logic [TS_W-1:0]     first_fault_time;
   logic [1:0]          state;

   modport master (
      output en, mode, d,
      input  q, fault_mask, fault_any, fault_count, first_fault_time, state
   );

   modport slave (
      input  en, mode, d,
      output q, fault_mask, fault_any, fault_count, first_fault_time, state
   );
endinterface

// File: rtl/clk_wiz_0.sv
// Behavioural stand-in for the clk_wiz_0 MMCM used by simulation and lint;
// the generated Vivado IP replaces this module in the implementation flow.
module clk_wiz_0 (
   input  logic clk_in1_p,
   input  logic clk_in1_n,
   input  logic reset,
   output logic clk_out1,
   output logic locked
);
   logic unused_inputs;

   assign clk_out1      = clk_in1_p;
   assign locked        = ~reset;
   assign unused_inputs = clk_in1_n;
endmodule

// File: rtl/fault_reg_bank_maj_vote.sv
// Bitwise majority over CHANNELS copies of a WIDTH-bit word; CHANNELS is
// odd, so every bit has a strict majority.
module maj_vote #(
   parameter int CHANNELS = 5,
   parameter int WIDTH    = 8
) (
   input  logic [CHANNELS-1:0][WIDTH-1:0] votes,
   output logic [WIDTH-1:0]               q
);
   localparam int CW = $clog2(CHANNELS + 1);

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic [CW-1:0] ones;

         always_comb begin
            ones = '0;
            for (int c = 0; c < CHANNELS; c++) begin
               ones = ones + CW'(votes[c][gi]);
            end
         end

         assign q[gi] = (ones > CW'(CHANNELS / 2));
      end
   endgenerate
endmodule

// File: rtl/fault_reg_bank.sv
// Laser-fault target: CHANNELS redundant register copies compared every cycle
// against a golden register, with sticky flags, counters and a voted output.
module fault_reg_bank
   import fault_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 5,
   parameter int CNT_W    = 16,
   parameter int TS_W     = 24
) (
   input  logic            sysclk_p,
   input  logic            sysclk_n,
   input  logic            reset,
   fault_reg_bank_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [TS_W-1:0]  TS_MAX  = '1;

   logic clk;
   logic mmcm_locked_unused;

   // MMCM reset tied low so clk keeps running through design reset.
   clk_wiz_0 u_clk_wiz (
      .clk_in1_p (sysclk_p),
      .clk_in1_n (sysclk_n),
      .reset     (1'b0),
      .clk_out1  (clk),
      .locked    (mmcm_locked_unused)
   );

   state_t                        state_reg;
   logic [WIDTH-1:0]              golden_reg;
   logic [TS_W-1:0]               ts_reg;
   logic [CHANNELS-1:0]           mask_reg;
   logic [CNT_W-1:0]              count_reg;
   logic [TS_W-1:0]               fft_reg;
   logic [CHANNELS-1:0][WIDTH-1:0] chan_q;
   logic [CHANNELS-1:0]           mism;
   logic                          arm;
   logic                          run;

   assign arm = (state_reg == ST_IDLE) && bus.en;
   assign run = (state_reg != ST_IDLE) && bus.en;

   // Copies must stay physically distinct; the build also enables
   // keep_equivalent_registers so synthesis does not merge them.
   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
         (* DONT_TOUCH = "TRUE" *) logic [WIDTH-1:0] chan_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               chan_reg <= '0;
            end else if (arm) begin
               chan_reg <= bus.d;
            end else if (run && bus.mode) begin
               chan_reg <= ~chan_reg;
            end
         end

         assign chan_q[gi] = chan_reg;
         assign mism[gi]   = (chan_reg != golden_reg);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         golden_reg <= '0;
         ts_reg     <= '0;
         mask_reg   <= '0;
         count_reg  <= '0;
         fft_reg    <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (bus.en) begin
                  golden_reg <= bus.d;
                  ts_reg     <= '0;
                  mask_reg   <= '0;
                  count_reg  <= '0;
                  fft_reg    <= '0;
                  state_reg  <= ST_MONITOR;
               end
            end
            ST_MONITOR, ST_FAULT: begin
               if (!bus.en) begin
                  state_reg <= ST_IDLE;
               end else begin
                  if (bus.mode) begin
                     golden_reg <= ~golden_reg;
                  end
                  ts_reg   <= TS_W'(sat_inc(SAT_W'(ts_reg), SAT_W'(TS_MAX)));
                  mask_reg <= mask_reg | mism;
                  if (|mism) begin
                     count_reg <= CNT_W'(sat_inc(SAT_W'(count_reg), SAT_W'(CNT_MAX)));
                     state_reg <= ST_FAULT;
                     // Timestamp only the very first mismatching cycle of a run.
                     if (mask_reg == '0) begin
                        fft_reg <= ts_reg;
                     end
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   maj_vote #(
      .CHANNELS (CHANNELS),
      .WIDTH    (WIDTH)
   ) u_maj_vote (
      .votes (chan_q),
      .q     (bus.q)
   );

   assign bus.fault_mask       = mask_reg;
   assign bus.fault_any        = |mask_reg;
   assign bus.fault_count      = count_reg;
   assign bus.first_fault_time = fft_reg;
   assign bus.state            = state_reg;
endmodule

// File: tb/tb_fault_reg_bank.sv
// Directed vectors for fault_reg_bank: arm/hold/toggle, injected upsets via
// force on individual copies, saturation and reset corner cases.
module tb_fault_reg_bank;
   localparam int WIDTH    = 8;
   localparam int CHANNELS = 5;
   localparam int CNT_W    = 16;
   localparam int TS_W     = 4;   // small so timestamp saturation is reachable

   localparam logic [1:0] IDL = 2'b00;
   localparam logic [1:0] MON = 2'b01;
   localparam logic [1:0] FLT = 2'b10;

   typedef struct {
      logic             rst;
      logic             en;
      logic             mode;
      logic [7:0]       d;
      logic [4:0]       fm;
      logic [7:0]       fv;
      logic [1:0]       st;
      logic [7:0]       q;
      logic [4:0]       mask;
      logic [15:0]      cnt;
      logic [3:0]       fft;
   } vec_t;

   logic sysclk_p;
   logic sysclk_n;
   logic reset;
   logic [7:0] force_val;
   logic [4:0] forced;
   int total;
   int bad;
   vec_t vq[$];

   fault_reg_bank_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CNT_W(CNT_W), .TS_W(TS_W)) bus ();

   fault_reg_bank #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CNT_W(CNT_W), .TS_W(TS_W)) dut (
      .sysclk_p (sysclk_p),
      .sysclk_n (sysclk_n),
      .reset    (reset),
      .bus      (bus)
   );

   initial begin
      sysclk_p = 1'b0;
      forever #5 sysclk_p = ~sysclk_p;
   end
   assign sysclk_n = ~sysclk_p;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply_force(input logic [4:0] fm, input logic [7:0] v);
      force_val = v;
      if (fm[0]) force dut.g_chan[0].chan_reg = force_val; else if (forced[0]) release dut.g_chan[0].chan_reg;
      if (fm[1]) force dut.g_chan[1].chan_reg = force_val; else if (forced[1]) release dut.g_chan[1].chan_reg;
      if (fm[2]) force dut.g_chan[2].chan_reg = force_val; else if (forced[2]) release dut.g_chan[2].chan_reg;
      if (fm[3]) force dut.g_chan[3].chan_reg = force_val; else if (forced[3]) release dut.g_chan[3].chan_reg;
      if (fm[4]) force dut.g_chan[4].chan_reg = force_val; else if (forced[4]) release dut.g_chan[4].chan_reg;
      forced = fm;
   endtask

   task automatic step(input logic rst, input logic en, input logic mode, input logic [7:0] d);
      reset    = rst;
      bus.en   = en;
      bus.mode = mode;
      bus.d    = d;
      @(posedge sysclk_p);
      #1;
   endtask

   task automatic add(input logic rst, input logic en, input logic mode, input logic [7:0] d,
                      input logic [4:0] fm, input logic [7:0] fv, input logic [1:0] st,
                      input logic [7:0] q, input logic [4:0] mask, input logic [15:0] cnt,
                      input logic [3:0] fft);
      vec_t v;
      v.rst = rst; v.en = en; v.mode = mode; v.d = d; v.fm = fm; v.fv = fv;
      v.st = st; v.q = q; v.mask = mask; v.cnt = cnt; v.fft = fft;
      vq.push_back(v);
   endtask

   task automatic show(input string tag);
      $display("%s: st=%0d q=%02h mask=%b any=%0b cnt=%0d fft=%0d", tag, bus.state, bus.q,
               bus.fault_mask, bus.fault_any, bus.fault_count, bus.first_fault_time);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      forced    = '0;
      force_val = '0;
      reset     = 1'b1;
      bus.en    = 1'b0;
      bus.mode  = 1'b0;
      bus.d     = '0;

      //   rst en md d      force    fv     st   q      mask      cnt  fft
      add(1, 0, 0, 8'h00, 5'b00000, 8'h00, IDL, 8'h00, 5'b00000, 0, 0);  // 0 reset
      add(1, 1, 0, 8'hA5, 5'b00000, 8'h00, IDL, 8'h00, 5'b00000, 0, 0);  // 1 reset beats en
      add(0, 1, 0, 8'hA5, 5'b00000, 8'h00, MON, 8'hA5, 5'b00000, 0, 0);  // 2 arm
      add(0, 1, 0, 8'hA5, 5'b00000, 8'h00, MON, 8'hA5, 5'b00000, 0, 0);  // 3 ts=1
      add(0, 1, 0, 8'hA5, 5'b00000, 8'h00, MON, 8'hA5, 5'b00000, 0, 0);  // 4 ts=2
      add(0, 1, 0, 8'hA5, 5'b00000, 8'h00, MON, 8'hA5, 5'b00000, 0, 0);  // 5 ts=3
      add(0, 1, 0, 8'hA5, 5'b00100, 8'hA4, FLT, 8'hA5, 5'b00100, 1, 3);  // 6 upset ch2
      add(0, 1, 0, 8'hA5, 5'b00100, 8'hA4, FLT, 8'hA5, 5'b00100, 2, 3);
      add(0, 1, 0, 8'hA5, 5'b00100, 8'hA4, FLT, 8'hA5, 5'b00100, 3, 3);
      add(0, 1, 0, 8'hA5, 5'b00100, 8'hA4, FLT, 8'hA5, 5'b00100, 4, 3);
      add(0, 0, 0, 8'h3C, 5'b00000, 8'h00, IDL, 8'hA5, 5'b00100, 4, 3);  // 10 drop en: held
      add(0, 0, 0, 8'h3C, 5'b00000, 8'h00, IDL, 8'hA5, 5'b00100, 4, 3);
      add(0, 1, 0, 8'h3C, 5'b00000, 8'h00, MON, 8'h3C, 5'b00000, 0, 0);  // 12 re-arm
      add(0, 1, 0, 8'h3C, 5'b00000, 8'h00, MON, 8'h3C, 5'b00000, 0, 0);
      add(1, 0, 1, 8'h0F, 5'b00000, 8'h00, IDL, 8'h00, 5'b00000, 0, 0);  // 14 reset
      add(0, 1, 1, 8'h0F, 5'b00000, 8'h00, MON, 8'h0F, 5'b00000, 0, 0);  // 15 arm, toggle mode
      add(0, 1, 1, 8'h0F, 5'b00000, 8'h00, MON, 8'hF0, 5'b00000, 0, 0);
      add(0, 1, 1, 8'h0F, 5'b00000, 8'h00, MON, 8'h0F, 5'b00000, 0, 0);
      add(0, 1, 1, 8'h0F, 5'b00000, 8'h00, MON, 8'hF0, 5'b00000, 0, 0);
      add(0, 1, 1, 8'h0F, 5'b10001, 8'h55, FLT, 8'h0F, 5'b10001, 1, 3);  // 19 upset ch0+ch4
      add(0, 1, 1, 8'h0F, 5'b10001, 8'h55, FLT, 8'hF0, 5'b10001, 2, 3);
      add(0, 1, 1, 8'h0F, 5'b10001, 8'h55, FLT, 8'h0F, 5'b10001, 3, 3);
      add(1, 1, 1, 8'h0F, 5'b10001, 8'h55, IDL, 8'h00, 5'b00000, 0, 0);  // 22 reset with live mismatch
      add(0, 0, 0, 8'h00, 5'b00000, 8'h00, IDL, 8'h00, 5'b00000, 0, 0);
      add(0, 1, 0, 8'hA5, 5'b00000, 8'h00, MON, 8'hA5, 5'b00000, 0, 0);  // 24 arm
      add(0, 1, 1, 8'hA5, 5'b00000, 8'h00, MON, 8'h5A, 5'b00000, 0, 0);  // 25 mode change only
      add(0, 1, 0, 8'hA5, 5'b00000, 8'h00, MON, 8'h5A, 5'b00000, 0, 0);
      add(0, 1, 1, 8'hA5, 5'b00000, 8'h00, MON, 8'hA5, 5'b00000, 0, 0);

      for (int i = 0; i < vq.size(); i++) begin
         apply_force(vq[i].fm, vq[i].fv);
         step(vq[i].rst, vq[i].en, vq[i].mode, vq[i].d);
         show($sformatf("vec %0d", i));
         check($sformatf("v%0d state", i), 64'(bus.state), 64'(vq[i].st));
         check($sformatf("v%0d q", i), 64'(bus.q), 64'(vq[i].q));
         check($sformatf("v%0d mask", i), 64'(bus.fault_mask), 64'(vq[i].mask));
         check($sformatf("v%0d any", i), 64'(bus.fault_any), 64'(|vq[i].mask));
         check($sformatf("v%0d count", i), 64'(bus.fault_count), 64'(vq[i].cnt));
         check($sformatf("v%0d fft", i), 64'(bus.first_fault_time), 64'(vq[i].fft));
      end

      // Timestamp saturates at 15 yet first_fault_time is still captured.
      apply_force(5'b00000, 8'h00);
      step(1, 0, 0, 8'h00);
      step(0, 1, 0, 8'hA5);
      for (int i = 0; i < 20; i++) step(0, 1, 0, 8'hA5);
      apply_force(5'b01000, 8'h00);
      step(0, 1, 0, 8'hA5);
      show("ts_sat first");
      check("ts_sat fft", 64'(bus.first_fault_time), 64'd15);
      check("ts_sat mask", 64'(bus.fault_mask), 64'b01000);
      check("ts_sat count", 64'(bus.fault_count), 64'd1);
      step(0, 1, 0, 8'hA5);
      show("ts_sat second");
      check("ts_sat fft hold", 64'(bus.first_fault_time), 64'd15);
      check("ts_sat count2", 64'(bus.fault_count), 64'd2);

      // Persistent upset for 70000 cycles: count saturates at 16'hFFFF.
      apply_force(5'b00000, 8'h00);
      step(1, 0, 0, 8'h00);
      step(0, 1, 0, 8'hA5);
      apply_force(5'b00010, 8'h00);
      for (int n = 1; n <= 70000; n++) begin
         step(0, 1, 0, 8'hA5);
         if (n == 65534) begin
            show("cnt_sat 65534");
            check("cnt_sat pre", 64'(bus.fault_count), 64'hFFFE);
         end
      end
      show("cnt_sat 70000");
      check("cnt_sat count", 64'(bus.fault_count), 64'hFFFF);
      check("cnt_sat state", 64'(bus.state), 64'(FLT));
      check("cnt_sat mask", 64'(bus.fault_mask), 64'b00010);
      check("cnt_sat q", 64'(bus.q), 64'hA5);
      step(0, 1, 0, 8'hA5);
      show("cnt_sat 70001");
      check("cnt_sat nowrap", 64'(bus.fault_count), 64'hFFFF);
      apply_force(5'b00000, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fault_reg_bank.md
Name: fault_reg_bank

Overview:
- Parametrised successor to the single-register laser-fault target: CHANNELS identical WIDTH-bit register copies are loaded together, then held or toggled while each copy is compared every cycle against a golden register.
- Sticky per-channel fault flags, a saturating fault-cycle counter, a first-fault timestamp and a majority-voted output expose laser-induced upsets to the host/ILA.
- Sits at the top of the fault-injection target FPGA, clocked from the on-board differential oscillator through the MMCM.

Parameters:
- WIDTH, 8, bits per register copy.
- CHANNELS, 5, number of redundant copies; must be odd and >= 3.
- CNT_W, 16, width of fault_count.
- TS_W, 24, width of the timestamp and first_fault_time.

Ports:
- sysclk_p  in  1  differential clock input, positive.
- sysclk_n  in  1  differential clock input, negative.
- reset  in  1  synchronous, active-high reset.
- en  in  1  arm/run enable.
- mode  in  1  0 = hold pattern; 1 = toggle pattern every cycle.
- d  in  WIDTH  pattern loaded on arm.
- q  out  WIDTH  bitwise majority vote of all channel copies.
- fault_mask  out  CHANNELS  sticky per-channel mismatch flags.
- fault_any  out  1  OR of fault_mask.
- fault_count  out  CNT_W  cycles with at least one mismatch; saturating.
- first_fault_time  out  TS_W  timestamp of the first mismatch cycle.
- state  out  2  00 IDLE, 01 MONITOR, 10 FAULT.

Behaviour:
- Clocking: one clock. There is a single design clock, clk, which is clk_wiz_0 clk_out1 (100 MHz) driven from sysclk_p/sysclk_n. The MMCM reset input is tied to 0 so clk keeps running during reset. All logic uses posedge clk.
- Reset: synchronous and active-high; it overrides en. It clears:
  - every channel copy, the golden register and the timestamp counter to 0
  - q = 0, fault_mask = 0, fault_any = 0, fault_count = 0, first_fault_time = 0
  - state = IDLE
- IDLE:
  - Registers hold their values; the previous results stay readable.
  - en = 1 at edge k loads d into every channel copy (internal array chan_q) and into the golden register.
  - The same edge clears fault_mask, fault_count, first_fault_time and the timestamp, and moves to MONITOR.
- MONITOR/FAULT, each edge with en = 1:
  - If mode = 1, every channel copy and the golden register load their own bitwise inverse. If mode = 0, they hold.
  - The timestamp increments, saturating at all ones.
  - Comparison is registered. mism[i] = (chan_q[i] != golden), evaluated on the pre-edge values. At the edge, fault_mask[i] |= mism[i].
  - If any mism bit is set: fault_count increments (saturating at 2^CNT_W-1), state becomes FAULT, and first_fault_time captures the pre-edge timestamp only if fault_mask was all zero.
  - The first mismatch present in cycle k is therefore visible on the outputs after edge k+1.
  - FAULT keeps monitoring and counting. Faulty copies are never repaired, so a persistent upset counts every cycle.
- en = 0 in MONITOR/FAULT: go to IDLE at the next edge with no compare update; all results are held.
- q: combinational majority over the current chan_q, bit by bit. With CHANNELS odd there are never ties.
- fault_any: combinational OR of fault_mask.
- Mode change mid-run: takes effect at the next edge with no reload. The golden register follows the same rule, so a mode change alone never causes a mismatch.
- Boundaries:
  - Timestamp saturation freezes the timestamp at all ones; first_fault_time is still captured.
  - A mismatch on the same edge as reset is discarded.
  - Reset during FAULT returns to IDLE with everything cleared.
- Synthesis: keep_equivalent_registers must be set and DONT_TOUCH applied to chan_q so the copies are not merged.

Decomposition:
- Shared package fault_pkg holds:
  - the state encoding constants ST_IDLE, ST_MONITOR, ST_FAULT
  - a saturating-increment helper function
- Sub-modules:
  - clk_wiz_0 (existing IP) is the only instantiated IP.
  - One natural sub-module, maj_vote (parametrised CHANNELS x WIDTH combinational majority), drives q.

Test Plan:
- Reset, then en = 1 with d = 8'hA5, mode = 0, held 10 cycles → state = MONITOR, q = 8'hA5, fault_mask = 0, fault_count = 0.
- Same setup; after 3 monitor cycles force chan_q[2] = 8'hA4 (release next edge) → fault_mask = 5'b00100, state = FAULT, first_fault_time = 3, fault_count increments every cycle, q = 8'hA5 throughout.
- mode = 1, d = 8'h0F → q alternates 8'hF0/8'h0F each cycle with fault_any = 0. Then force chan_q[0] and chan_q[4] in the same cycle → fault_mask = 5'b10001, fault_count = 1 after one cycle and +1 every cycle while run.
- Force chan_q[1] to mismatch for 70000 cycles with CNT_W = 16 → fault_count saturates at 16'hFFFF and does not wrap.
- Drop en while in FAULT, then raise it with d = 8'h3C → outputs are held in IDLE; after re-arm fault_mask = 0, fault_count = 0, q = 8'h3C.
- Assert reset mid-FAULT in the same cycle as a new forced mismatch → next cycle all outputs are 0, state = IDLE, and no count increment occurs.
